// File: rtl/noc_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared types and helpers for the NoC output-port round-robin arbiter.
//   arb_state_e : lock FSM states (IDLE between packets, LOCKED mid-packet)
//   idx_w(n)    : width of a binary requester index, never less than 1
//   N_REQ_DEF   : default requester count (N/E/S/W/local)
//   CNT_W_DEF   : default grant-counter width
// -----------------------------------------------------------------------------
package noc_arb_pkg;

   localparam int N_REQ_DEF = 5;
   localparam int CNT_W_DEF = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // A single requester still needs a 1-bit index port.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter_if
// Request/grant bundle between the input ports and one output-port arbiter.
//   req       : per-requester flit-valid            (master -> slave)
//   last      : per-requester tail-flit flag        (master -> slave)
//   out_ready : downstream accepts the granted flit (master -> slave)
//   gnt       : one-hot grant or zero               (slave -> master)
//   gnt_valid : |gnt                                (slave -> master)
//   gnt_idx   : binary index of the grant, 0 if none (slave -> master)
//   locked    : a multi-flit packet is in progress  (slave -> master)
// -----------------------------------------------------------------------------
interface noc_rr_arbiter_if
   import noc_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) ();

   localparam int IDX_W = idx_w(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] last;
   logic             out_ready;
   logic [N_REQ-1:0] gnt;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic             locked;

   modport master (
      output req, last, out_ready,
      input  gnt, gnt_valid, gnt_idx, locked
   );

   modport slave (
      input  req, last, out_ready,
      output gnt, gnt_valid, gnt_idx, locked
   );

endinterface

// File: rtl/noc_rr_arbiter_prio_onehot.sv
// -----------------------------------------------------------------------------
// noc_prio_onehot
// Fixed-priority selector: the lowest set bit of req_i wins.
//   req_i : request vector
//   gnt_o : one-hot of the winner, zero when req_i is zero
//   idx_o : binary index of the winner, zero when req_i is zero
//   any_o : |req_i
// -----------------------------------------------------------------------------
module noc_prio_onehot
   import noc_arb_pkg::*;
#(
   parameter int WIDTH = N_REQ_DEF
) (
   input  logic [WIDTH-1:0]        req_i,
   output logic [WIDTH-1:0]        gnt_o,
   output logic [idx_w(WIDTH)-1:0] idx_o,
   output logic                    any_o
);

   localparam int IDX_W = idx_w(WIDTH);

   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = |req_i;
      // Walk from the top down so the lowest set bit is the last one written.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            gnt_o    = '0;
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
// Round-robin arbiter for one NoC router output port, with packet lock.
// Grant is combinational from the request lines and registered state; the
// rotating pointer only advances when a packet ends, so fairness is per packet.
//   clk, rst_n : clock, asynchronous active-low reset
//   arb        : noc_rr_arbiter_if.slave (req/last/out_ready in,
//                gnt/gnt_valid/gnt_idx/locked out)
//   gnt_cnt    : per-requester completed-packet counters, saturating; present
//                only when NOC_RR_ARB_GRANT_CNT_EN is defined
// -----------------------------------------------------------------------------
module noc_rr_arbiter
   import noc_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   noc_rr_arbiter_if.slave  arb
`ifdef NOC_RR_ARB_GRANT_CNT_EN
   ,
   output logic [CNT_W-1:0] gnt_cnt [N_REQ]
`endif
);

   localparam int IDX_W = idx_w(N_REQ);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;

   logic [N_REQ-1:0] mask;
   logic [N_REQ-1:0] m_gnt, u_gnt, gnt;
   logic [IDX_W-1:0] m_idx, u_idx, gnt_idx;
   logic             m_any, u_any;
   logic             xfer, last_win;

   // Requesters strictly after the previous winner get first pick.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N_REQ; i++) mask[i] = (i > int'(ptr_q));
   end

   noc_prio_onehot #(.WIDTH(N_REQ)) u_masked (
      .req_i (arb.req & mask),
      .gnt_o (m_gnt),
      .idx_o (m_idx),
      .any_o (m_any)
   );

   noc_prio_onehot #(.WIDTH(N_REQ)) u_unmasked (
      .req_i (arb.req),
      .gnt_o (u_gnt),
      .idx_o (u_idx),
      .any_o (u_any)
   );

   // Output logic: while locked only the owner may be granted.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      if (state_q == LOCKED) begin
         if (arb.req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            gnt_idx      = owner_q;
         end
      end else if (m_any) begin
         gnt     = m_gnt;
         gnt_idx = m_idx;
      end else if (u_any) begin
         gnt     = u_gnt;
         gnt_idx = u_idx;
      end
   end

   assign arb.gnt       = gnt;
   assign arb.gnt_valid = |gnt;
   assign arb.gnt_idx   = gnt_idx;
   assign arb.locked    = (state_q == LOCKED);

   assign xfer     = (|gnt) && arb.out_ready;
   // Indexed only by the granted requester, so last bits of idle lanes are ignored.
   assign last_win = arb.last[gnt_idx];

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      if (xfer) begin
         unique case (state_q)
            IDLE: begin
               if (last_win) begin
                  ptr_d = gnt_idx;
               end else begin
                  owner_d = gnt_idx;
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (last_win) begin
                  ptr_d   = owner_q;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IDX_W'(N_REQ - 1);
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

`ifdef NOC_RR_ARB_GRANT_CNT_EN
   logic [CNT_W-1:0] cnt_q [N_REQ];

   // NOTE: the counter array is a handful of flops, not a RAM, so it takes the
   // async reset like any other register and software always reads 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (xfer && last_win && (int'(gnt_idx) == i) && (cnt_q[i] != '1))
               cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_rr_arbiter
// Directed scenarios plus randomized traffic checked against a rotating-priority
// reference model. Define NOC_RR_ARB_GRANT_CNT_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_noc_rr_arbiter;

   localparam int N     = 5;
   localparam int CNT_W = 2;
   localparam int IDX_W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] last = '0;
   logic         out_ready = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int m_ptr   = N - 1;
   bit m_lock  = 1'b0;
   int m_owner = 0;
   int m_cnt [N];

   always #5 clk = ~clk;

   noc_rr_arbiter_if #(.N_REQ(N)) bus ();
   assign bus.req       = req;
   assign bus.last      = last;
   assign bus.out_ready = out_ready;

`ifdef NOC_RR_ARB_GRANT_CNT_EN
   logic [CNT_W-1:0] gnt_cnt [N];
`endif

   noc_rr_arbiter #(.N_REQ(N), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .arb     (bus)
`ifdef NOC_RR_ARB_GRANT_CNT_EN
      ,
      .gnt_cnt (gnt_cnt)
`endif
   );

   // ---------------- reference model ----------------
   function automatic int model_winner(input logic [N-1:0] r);
      if (m_lock) return r[m_owner] ? m_owner : -1;
      for (int k = 1; k <= N; k++) begin
         int i = (m_ptr + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] v = '0;
      if (w >= 0) v[w] = 1'b1;
      return v;
   endfunction

   function automatic void model_reset();
      m_ptr   = N - 1;
      m_lock  = 1'b0;
      m_owner = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endfunction

   function automatic void model_step();
      int w = model_winner(req);
      if (w < 0 || !out_ready) return;
      if (last[w]) begin
         m_ptr  = w;
         m_lock = 1'b0;
         if (m_cnt[w] < (1 << CNT_W) - 1) m_cnt[w]++;
      end else if (!m_lock) begin
         m_lock  = 1'b1;
         m_owner = w;
      end
   endfunction

   // ---------------- drivers (no checking) ----------------
   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
      @(negedge clk);
      req = r; last = l; out_ready = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0; last = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      drive('0, '1, 1'b1);
      n_vec++;
      if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== '0 || bus.locked !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: gnt=%b valid=%b idx=%0d locked=%b expected 0/0/0/0",
                  bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.locked);
      end
      tick();
      // out_ready with nothing granted must not move the pointer.
      drive(5'b11111, 5'b11111, 1'b0);
      n_vec++;
      if (bus.gnt !== 5'b00001) begin
         n_err++;
         $display("FAIL reset_prio: gnt=%b expected 00001", bus.gnt);
      end
      tick();
   endtask

   task automatic test_rotation();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         logic [N-1:0] e = onehot(k % N);
         drive(5'b11111, 5'b11111, 1'b1);
         n_vec++;
         if (bus.gnt !== e || bus.gnt_idx !== IDX_W'(k % N) || bus.gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rotation[%0d]: gnt=%b idx=%0d expected %b idx=%0d",
                     k, bus.gnt, bus.gnt_idx, e, k % N);
         end
         tick();
      end
   endtask

   task automatic test_two_req();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         logic [N-1:0] e = (k % 2 == 0) ? 5'b00001 : 5'b10000;
         drive(5'b10001, 5'b11111, 1'b1);
         n_vec++;
         if (bus.gnt !== e) begin
            n_err++;
            $display("FAIL two_req[%0d]: gnt=%b expected %b", k, bus.gnt, e);
         end
         tick();
      end
   endtask

   task automatic test_packet_lock();
      logic [N-1:0] lv [3] = '{5'b00001, 5'b00001, 5'b00101};
      do_reset();
      drive(5'b00010, 5'b00010, 1'b1);   // single flit from 1: pointer -> 1
      n_vec++;
      if (bus.gnt !== 5'b00010) begin
         n_err++;
         $display("FAIL lock_setup: gnt=%b expected 00010", bus.gnt);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(5'b00101, lv[k], 1'b1);
         n_vec++;
         if (bus.gnt !== 5'b00100 || bus.locked !== (k > 0)) begin
            n_err++;
            $display("FAIL lock_flit[%0d]: gnt=%b locked=%b expected 00100 locked=%b",
                     k, bus.gnt, bus.locked, k > 0);
         end
         tick();
      end
      drive(5'b00101, 5'b00101, 1'b0);
      n_vec++;
      if (bus.gnt !== 5'b00001 || bus.locked !== 1'b0) begin
         n_err++;
         $display("FAIL lock_after: gnt=%b locked=%b expected 00001 locked=0", bus.gnt, bus.locked);
      end
      tick();
   endtask

   task automatic test_owner_drop();
      do_reset();
      drive(5'b00010, 5'b00010, 1'b1);
      tick();
      drive(5'b00101, 5'b00000, 1'b1);   // owner 2 starts a packet
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(5'b00001, 5'b00001, 1'b1);
         n_vec++;
         if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.locked !== 1'b1) begin
            n_err++;
            $display("FAIL owner_drop[%0d]: gnt=%b valid=%b locked=%b expected 0/0/1",
                     k, bus.gnt, bus.gnt_valid, bus.locked);
         end
         tick();
      end
      drive(5'b00101, 5'b00100, 1'b1);
      n_vec++;
      if (bus.gnt !== 5'b00100) begin
         n_err++;
         $display("FAIL owner_return: gnt=%b expected 00100", bus.gnt);
      end
      tick();
      drive(5'b00101, 5'b00101, 1'b0);
      n_vec++;
      if (bus.locked !== 1'b0 || bus.gnt !== 5'b00001) begin
         n_err++;
         $display("FAIL owner_unlock: gnt=%b locked=%b expected 00001 locked=0", bus.gnt, bus.locked);
      end
      tick();
   endtask

   task automatic test_stall_and_reset();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(5'b00110, 5'b00110, 1'b0);
         n_vec++;
         if (bus.gnt !== 5'b00010) begin
            n_err++;
            $display("FAIL stall[%0d]: gnt=%b expected 00010", k, bus.gnt);
         end
         tick();
      end
      drive(5'b00110, 5'b00000, 1'b1);   // winner 1 still (pointer unchanged), starts packet
      n_vec++;
      if (bus.gnt !== 5'b00010) begin
         n_err++;
         $display("FAIL stall_ptr: gnt=%b expected 00010", bus.gnt);
      end
      tick();
      drive(5'b11111, 5'b00000, 1'b0);
      n_vec++;
      if (bus.locked !== 1'b1 || bus.gnt !== 5'b00010) begin
         n_err++;
         $display("FAIL pre_reset: gnt=%b locked=%b expected 00010 locked=1", bus.gnt, bus.locked);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (bus.locked !== 1'b0 || bus.gnt !== 5'b00001 || bus.gnt_idx !== '0) begin
         n_err++;
         $display("FAIL async_reset: gnt=%b idx=%0d locked=%b expected 00001 idx=0 locked=0",
                  bus.gnt, bus.gnt_idx, bus.locked);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         logic [N-1:0] r = N'($urandom_range(0, 31));
         logic [N-1:0] l = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 31)) : '1;
         logic         rd = ($urandom_range(0, 3) != 0);
         int           w;
         logic [N-1:0] e;
         if ($urandom_range(0, 7) == 0) r = '0;
         drive(r, l, rd);
         w = model_winner(r);
         e = onehot(w);
         n_vec++;
         if (bus.gnt !== e || bus.gnt_valid !== (w >= 0) ||
             bus.gnt_idx !== IDX_W'((w < 0) ? 0 : w) || bus.locked !== m_lock) begin
            n_err++;
            $display("FAIL random[%0d]: req=%b gnt=%b idx=%0d locked=%b expected %b idx=%0d locked=%b",
                     k, r, bus.gnt, bus.gnt_idx, bus.locked, e, (w < 0) ? 0 : w, m_lock);
         end
`ifdef NOC_RR_ARB_GRANT_CNT_EN
         for (int i = 0; i < N; i++) begin
            n_vec++;
            if (int'(gnt_cnt[i]) !== m_cnt[i]) begin
               n_err++;
               $display("FAIL random_cnt[%0d][%0d]: cnt=%0d expected %0d", k, i, gnt_cnt[i], m_cnt[i]);
            end
         end
`endif
         tick();
      end
   endtask

`ifdef NOC_RR_ARB_GRANT_CNT_EN
   task automatic test_grant_cnt();
      do_reset();
      repeat (5) begin
         drive(5'b00010, 5'b00010, 1'b1);
         tick();
      end
      drive('0, '0, 1'b0);
      for (int i = 0; i < N; i++) begin
         int e = (i == 1) ? 3 : 0;
         n_vec++;
         if (int'(gnt_cnt[i]) !== e) begin
            n_err++;
            $display("FAIL grant_cnt[%0d]: cnt=%0d expected %0d", i, gnt_cnt[i], e);
         end
      end
      tick();
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_rotation();
      test_two_req();
      test_packet_lock();
      test_owner_drop();
      test_stall_and_reset();
`ifdef NOC_RR_ARB_GRANT_CNT_EN
      test_grant_cnt();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
